// File: rtl/input4_debounce.sv
// Switch front end for the 4-input AOI gate: per-channel synchronizer and debouncer,
// plus a scan mode that walks {a,b,c,d} through 0000..1111 at a fixed step rate.
module input4_debounce #(
  parameter int STABLE_COUNT = 50000,
  parameter int CNT_WIDTH    = 16,
  parameter int STEP_CYCLES  = 50000000,
  parameter int STEP_WIDTH   = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_in,
  input  logic       scan_en,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       chg
);

  localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [STEP_WIDTH-1:0] STEP_LAST = STEP_WIDTH'(STEP_CYCLES - 1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } deb_state_t;

  logic [3:0] deb;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      logic                 s1_reg;
      logic                 s2_reg;
      logic                 deb_reg;
      logic                 deb_next;
      logic [CNT_WIDTH-1:0] cnt_reg;
      logic [CNT_WIDTH-1:0] cnt_next;
      deb_state_t           state;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_reg  <= 1'b0;
          s2_reg  <= 1'b0;
          deb_reg <= 1'b0;
          cnt_reg <= '0;
        end else begin
          s1_reg  <= sw_in[gi];
          s2_reg  <= s1_reg;
          deb_reg <= deb_next;
          cnt_reg <= cnt_next;
        end
      end

      // The FSM state is implied by whether the synchronized level disagrees with deb.
      always_comb begin
        deb_next = deb_reg;
        cnt_next = '0;
        state    = (s2_reg == deb_reg) ? STABLE : PENDING;
        case (state)
          STABLE: cnt_next = '0;
          PENDING: begin
            if (cnt_reg == CNT_LAST) begin
              deb_next = s2_reg;
              cnt_next = '0;
            end else begin
              cnt_next = cnt_reg + CNT_WIDTH'(1);
            end
          end
          default: cnt_next = '0;
        endcase
      end

      assign deb[gi] = deb_reg;
    end
  endgenerate

  logic                  scan_q_reg;
  logic [3:0]            pattern_reg;
  logic [3:0]            pattern_next;
  logic [STEP_WIDTH-1:0] timer_reg;
  logic [STEP_WIDTH-1:0] timer_next;
  logic [3:0]            out_reg;
  logic [3:0]            out_next;
  logic                  chg_reg;

  // Outputs load pattern_next so the entry value and every step are held the full step time.
  always_comb begin
    pattern_next = pattern_reg;
    timer_next   = timer_reg;
    if (scan_en && !scan_q_reg) begin
      pattern_next = 4'd0;
      timer_next   = '0;
    end else if (scan_en) begin
      if (timer_reg == STEP_LAST) begin
        timer_next   = '0;
        pattern_next = pattern_reg + 4'd1;
      end else begin
        timer_next = timer_reg + STEP_WIDTH'(1);
      end
    end
    out_next = scan_en ? pattern_next : deb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q_reg  <= 1'b0;
      pattern_reg <= 4'd0;
      timer_reg   <= '0;
      out_reg     <= 4'd0;
      chg_reg     <= 1'b0;
    end else begin
      scan_q_reg  <= scan_en;
      pattern_reg <= pattern_next;
      timer_reg   <= timer_next;
      out_reg     <= out_next;
      chg_reg     <= (out_next != out_reg);
    end
  end

  assign a   = out_reg[3];
  assign b   = out_reg[2];
  assign c   = out_reg[1];
  assign d   = out_reg[0];
  assign chg = chg_reg;

endmodule
